// File: rtl/mem_pkg.sv
// Shared memory-stage types: access-size encoding, WB result select, and the
// bundled control word carried through the EX->MEM register.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_type_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic      valid;
        logic      reg_write;
        logic      mem_write;
        logic      mem_read;
        logic      misaligned;
        logic [1:0] result_src;
        mem_type_t type_control;
        logic      sign_ext_flag;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_if.sv
// EX->MEM boundary bundle: pipeline control, EX-stage fields in, registered MEM-stage fields out.
interface ex_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stall_m;
    logic                  flush_m;
    logic                  valid_e;
    logic                  reg_write_e;
    logic                  mem_write_e;
    logic                  mem_read_e;
    logic [1:0]            result_src_e;
    logic [1:0]            type_control_e;
    logic                  sign_ext_flag_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [DATA_WIDTH-1:0] alu_result_e;
    logic [DATA_WIDTH-1:0] write_data_e;
    logic [DATA_WIDTH-1:0] pc_plus4_e;

    logic                  valid_m;
    logic                  reg_write_m;
    logic                  mem_write_m;
    logic                  mem_read_m;
    logic [1:0]            result_src_m;
    logic [1:0]            type_control_m;
    logic                  sign_ext_flag_m;
    logic [REG_ADDR_W-1:0] rd_m;
    logic [DATA_WIDTH-1:0] alu_result_m;
    logic [DATA_WIDTH-1:0] write_data_m;
    logic [DATA_WIDTH-1:0] pc_plus4_m;
    logic                  misaligned_m;

    // EX stage / hazard unit side
    modport master (
        output stall_m, flush_m, valid_e, reg_write_e, mem_write_e, mem_read_e,
               result_src_e, type_control_e, sign_ext_flag_e, rd_e,
               alu_result_e, write_data_e, pc_plus4_e,
        input  valid_m, reg_write_m, mem_write_m, mem_read_m, result_src_m,
               type_control_m, sign_ext_flag_m, rd_m, alu_result_m,
               write_data_m, pc_plus4_m, misaligned_m
    );

    // Pipeline register side
    modport slave (
        input  stall_m, flush_m, valid_e, reg_write_e, mem_write_e, mem_read_e,
               result_src_e, type_control_e, sign_ext_flag_e, rd_e,
               alu_result_e, write_data_e, pc_plus4_e,
        output valid_m, reg_write_m, mem_write_m, mem_read_m, result_src_m,
               type_control_m, sign_ext_flag_m, rd_m, alu_result_m,
               write_data_m, pc_plus4_m, misaligned_m
    );
endinterface

// File: rtl/ex_mem_pipe_reg_align_check.sv
// Combinational alignment check of an access address against its size.
module align_check
    import mem_pkg::*;
(
    input  logic [1:0] addr_lsb,
    input  mem_type_t  mem_type,
    output logic       misaligned
);

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        misaligned = 1'b1;
        case (mem_type)
            MEM_BYTE: misaligned = 1'b0;
            MEM_HALF: misaligned = addr_lsb[0];
            MEM_WORD: misaligned = |addr_lsb;
            default:  misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/flush, valid tracking and misaligned-access
// suppression; registered rd/reg_write/alu_result also feed the forwarding unit.
module ex_mem_pipe_reg
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic   clk,
    input  logic   rst,
    ex_mem_if.slave bus
);

    ex_mem_ctrl_t          ctrl_d;
    ex_mem_ctrl_t          ctrl_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] alu_result_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [DATA_WIDTH-1:0] pc_plus4_q;

    mem_type_t type_e;
    logic      addr_bad;
    logic      mis;

    assign type_e = mem_type_t'(bus.type_control_e);

    align_check u_align_check (
        .addr_lsb   (bus.alu_result_e[1:0]),
        .mem_type   (type_e),
        .misaligned (addr_bad)
    );

    // A trapped access must not reach memory or write back, so it is squashed here.
    always_comb begin
        mis                  = bus.valid_e & (bus.mem_read_e | bus.mem_write_e) & addr_bad;
        ctrl_d               = '0;
        ctrl_d.valid         = bus.valid_e;
        ctrl_d.misaligned    = mis;
        ctrl_d.mem_write     = bus.valid_e & bus.mem_write_e & ~mis;
        ctrl_d.mem_read      = bus.valid_e & bus.mem_read_e & ~mis;
        ctrl_d.reg_write     = bus.valid_e & bus.reg_write_e & (bus.rd_e != '0) & ~mis;
        ctrl_d.result_src    = bus.result_src_e;
        ctrl_d.type_control  = type_e;
        ctrl_d.sign_ext_flag = bus.sign_ext_flag_e;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every field samples pre-edge values together.
        if (rst) begin
            ctrl_q       <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else if (bus.flush_m) begin
            ctrl_q       <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else if (!bus.stall_m) begin
            ctrl_q       <= ctrl_d;
            rd_q         <= bus.rd_e;
            alu_result_q <= bus.alu_result_e;
            write_data_q <= bus.write_data_e;
            pc_plus4_q   <= bus.pc_plus4_e;
        end
    end

    assign bus.valid_m         = ctrl_q.valid;
    assign bus.reg_write_m     = ctrl_q.reg_write;
    assign bus.mem_write_m     = ctrl_q.mem_write;
    assign bus.mem_read_m      = ctrl_q.mem_read;
    assign bus.misaligned_m    = ctrl_q.misaligned;
    assign bus.result_src_m    = ctrl_q.result_src;
    assign bus.type_control_m  = ctrl_q.type_control;
    assign bus.sign_ext_flag_m = ctrl_q.sign_ext_flag;
    assign bus.rd_m            = rd_q;
    assign bus.alu_result_m    = alu_result_q;
    assign bus.write_data_m    = write_data_q;
    assign bus.pc_plus4_m      = pc_plus4_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg.
module tb_ex_mem_pipe_reg;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_mem_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) bus ();

    ex_mem_pipe_reg #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, rw, mw, mr, input logic [1:0] rs, tc,
                         input logic se, input logic [4:0] rd,
                         input logic [31:0] alu, wd, pc);
        bus.valid_e         = v;
        bus.reg_write_e     = rw;
        bus.mem_write_e     = mw;
        bus.mem_read_e      = mr;
        bus.result_src_e    = rs;
        bus.type_control_e  = tc;
        bus.sign_ext_flag_e = se;
        bus.rd_e            = rd;
        bus.alu_result_e    = alu;
        bus.write_data_e    = wd;
        bus.pc_plus4_e      = pc;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              2'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
    endtask

    function automatic logic [127:0] all_out();
        return {bus.valid_m, bus.reg_write_m, bus.mem_write_m, bus.mem_read_m,
                bus.result_src_m, bus.type_control_m, bus.sign_ext_flag_m, bus.rd_m,
                bus.alu_result_m, bus.write_data_m, bus.pc_plus4_m, bus.misaligned_m};
    endfunction

    task automatic test_reset();
        logic [127:0] snap;
        rst = 1'b1;
        bus.stall_m = 1'b0;
        bus.flush_m = 1'b0;
        drive_random();
        tick();
        drive_random();
        tick();
        checks++; if (all_out() !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_out()); end
        // release and capture an ADD rd=5
        rst = 1'b0;
        drive(1, 1, 0, 0, 2'b00, 2'b10, 0, 5'd5, 32'h10, 32'h55, 32'h104);
        tick();
        checks++; if (bus.reg_write_m !== 1'b1) begin failures++; $display("FAIL add_reg_write: got %b want 1", bus.reg_write_m); end
        checks++; if (bus.rd_m !== 5'd5) begin failures++; $display("FAIL add_rd: got %0d want 5", bus.rd_m); end
        checks++; if (bus.alu_result_m !== 32'h10) begin failures++; $display("FAIL add_alu: got %h want 10", bus.alu_result_m); end
        checks++; if (bus.valid_m !== 1'b1 || bus.pc_plus4_m !== 32'h104 || bus.write_data_m !== 32'h55)
            begin failures++; $display("FAIL add_fields: got v=%b pc=%h wd=%h want v=1 pc=104 wd=55", bus.valid_m, bus.pc_plus4_m, bus.write_data_m); end
        // asynchronous reset must clear before any clock edge
        snap = all_out();
        #2 rst = 1'b1;
        #1;
        checks++; if (all_out() !== '0 || snap === '0) begin failures++; $display("FAIL async_reset: before=%h after=%h want nonzero then 0", snap, all_out()); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_store_align();
        drive(1, 0, 1, 0, 2'b00, 2'b10, 0, 5'd0, 32'h1002, 32'hDEADBEEF, 32'h200);
        tick();
        checks++; if (bus.misaligned_m !== 1'b1 || bus.mem_write_m !== 1'b0)
            begin failures++; $display("FAIL sw_0x1002: got mis=%b mw=%b want mis=1 mw=0", bus.misaligned_m, bus.mem_write_m); end
        drive(1, 0, 1, 0, 2'b00, 2'b10, 0, 5'd0, 32'h1004, 32'hDEADBEEF, 32'h204);
        tick();
        checks++; if (bus.misaligned_m !== 1'b0 || bus.mem_write_m !== 1'b1 || bus.write_data_m !== 32'hDEADBEEF)
            begin failures++; $display("FAIL sw_0x1004: got mis=%b mw=%b wd=%h want mis=0 mw=1 wd=deadbeef", bus.misaligned_m, bus.mem_write_m, bus.write_data_m); end
        drive(1, 0, 1, 0, 2'b00, 2'b01, 0, 5'd0, 32'h1002, 32'h1234, 32'h208);
        tick();
        checks++; if (bus.misaligned_m !== 1'b0 || bus.mem_write_m !== 1'b1)
            begin failures++; $display("FAIL sh_0x1002: got mis=%b mw=%b want mis=0 mw=1", bus.misaligned_m, bus.mem_write_m); end
        drive(1, 0, 1, 0, 2'b00, 2'b11, 0, 5'd0, 32'h1000, 32'h1234, 32'h20C);
        tick();
        checks++; if (bus.misaligned_m !== 1'b1 || bus.mem_write_m !== 1'b0)
            begin failures++; $display("FAIL store_rsvd: got mis=%b mw=%b want mis=1 mw=0", bus.misaligned_m, bus.mem_write_m); end
    endtask

    task automatic test_load_align();
        drive(1, 1, 0, 1, 2'b01, 2'b01, 1, 5'd7, 32'h2001, 32'h0, 32'h300);
        tick();
        checks++; if (bus.misaligned_m !== 1'b1 || bus.mem_read_m !== 1'b0 || bus.reg_write_m !== 1'b0)
            begin failures++; $display("FAIL lh_0x2001: got mis=%b mr=%b rw=%b want 1 0 0", bus.misaligned_m, bus.mem_read_m, bus.reg_write_m); end
        checks++; if (bus.result_src_m !== 2'b01 || bus.type_control_m !== 2'b01 || bus.sign_ext_flag_m !== 1'b1)
            begin failures++; $display("FAIL lh_fields: got rs=%b tc=%b se=%b want 01 01 1", bus.result_src_m, bus.type_control_m, bus.sign_ext_flag_m); end
        drive(1, 1, 0, 1, 2'b01, 2'b00, 0, 5'd7, 32'h2003, 32'h0, 32'h304);
        tick();
        checks++; if (bus.misaligned_m !== 1'b0 || bus.mem_read_m !== 1'b1 || bus.reg_write_m !== 1'b1)
            begin failures++; $display("FAIL lb_0x2003: got mis=%b mr=%b rw=%b want 0 1 1", bus.misaligned_m, bus.mem_read_m, bus.reg_write_m); end
        drive(1, 1, 0, 1, 2'b01, 2'b10, 0, 5'd8, 32'h2002, 32'h0, 32'h308);
        tick();
        checks++; if (bus.misaligned_m !== 1'b1 || bus.reg_write_m !== 1'b0)
            begin failures++; $display("FAIL lw_0x2002: got mis=%b rw=%b want 1 0", bus.misaligned_m, bus.reg_write_m); end
        // non-memory op: odd ALU result is not an alignment fault
        drive(1, 1, 0, 0, 2'b00, 2'b10, 0, 5'd9, 32'h3, 32'h0, 32'h30C);
        tick();
        checks++; if (bus.misaligned_m !== 1'b0 || bus.reg_write_m !== 1'b1)
            begin failures++; $display("FAIL alu_odd: got mis=%b rw=%b want 0 1", bus.misaligned_m, bus.reg_write_m); end
    endtask

    task automatic test_stall();
        logic [127:0] held;
        drive(1, 1, 0, 1, 2'b01, 2'b10, 0, 5'd9, 32'h4000, 32'h0, 32'h104);
        tick();
        held = {1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 5'd9, 32'h4000, 32'h0, 32'h104, 1'b0};
        checks++; if (all_out() !== held) begin failures++; $display("FAIL stall_capture: got %h want %h", all_out(), held); end
        bus.stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 2'b10, 2'b00, 1, 5'd3 + 5'(i), 32'h5000 + i, 32'hAA, 32'h900);
            tick();
            checks++; if (all_out() !== held) begin failures++; $display("FAIL stall_hold_%0d: got %h want %h", i, all_out(), held); end
        end
        bus.stall_m = 1'b0;
        tick();
        checks++; if (bus.alu_result_m !== 32'h5002 || bus.rd_m !== 5'd5 || bus.mem_write_m !== 1'b1)
            begin failures++; $display("FAIL stall_release: got alu=%h rd=%0d mw=%b want 5002 5 1", bus.alu_result_m, bus.rd_m, bus.mem_write_m); end
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 0, 2'b00, 2'b10, 0, 5'd4, 32'h6000, 32'h77, 32'h400);
        tick();
        bus.stall_m = 1'b1;
        bus.flush_m = 1'b1;
        tick();
        checks++; if (bus.valid_m !== 1'b0 || bus.mem_write_m !== 1'b0 || bus.reg_write_m !== 1'b0)
            begin failures++; $display("FAIL flush_stall: got v=%b mw=%b rw=%b want 0 0 0", bus.valid_m, bus.mem_write_m, bus.reg_write_m); end
        checks++; if (all_out() !== '0) begin failures++; $display("FAIL flush_all_zero: got %h want 0", all_out()); end
        bus.stall_m = 1'b0;
        bus.flush_m = 1'b0;
        tick();
        bus.flush_m = 1'b1;
        tick();
        checks++; if (all_out() !== '0) begin failures++; $display("FAIL flush_only: got %h want 0", all_out()); end
        bus.flush_m = 1'b0;
    endtask

    task automatic test_qualify();
        drive(1, 1, 0, 0, 2'b00, 2'b10, 0, 5'd0, 32'h8, 32'h0, 32'h500);
        tick();
        checks++; if (bus.reg_write_m !== 1'b0 || bus.valid_m !== 1'b1)
            begin failures++; $display("FAIL rd_zero: got rw=%b v=%b want 0 1", bus.reg_write_m, bus.valid_m); end
        drive(0, 1, 1, 0, 2'b00, 2'b10, 0, 5'd6, 32'h8, 32'h99, 32'h504);
        tick();
        checks++; if (bus.mem_write_m !== 1'b0 || bus.valid_m !== 1'b0 || bus.reg_write_m !== 1'b0)
            begin failures++; $display("FAIL invalid_store: got mw=%b v=%b rw=%b want 0 0 0", bus.mem_write_m, bus.valid_m, bus.reg_write_m); end
        drive(0, 0, 1, 1, 2'b00, 2'b10, 0, 5'd6, 32'h9, 32'h99, 32'h508);
        tick();
        checks++; if (bus.misaligned_m !== 1'b0 || bus.mem_read_m !== 1'b0 || bus.alu_result_m !== 32'h9)
            begin failures++; $display("FAIL invalid_misaligned: got mis=%b mr=%b alu=%h want 0 0 9", bus.misaligned_m, bus.mem_read_m, bus.alu_result_m); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 0, 0, 2'b10, 2'b10, 0, 5'd1, 32'hA0, 32'h0, 32'hA4);
        tick();
        bus.stall_m = 1'b1;
        rst = 1'b1;
        tick();
        checks++; if (all_out() !== '0) begin failures++; $display("FAIL rst_in_stall: got %h want 0", all_out()); end
        rst = 1'b0;
        tick();
        checks++; if (all_out() !== '0) begin failures++; $display("FAIL rst_then_stall_hold: got %h want 0", all_out()); end
        bus.stall_m = 1'b0;
        tick();
        checks++; if (bus.valid_m !== 1'b1 || bus.result_src_m !== 2'b10 || bus.pc_plus4_m !== 32'hA4 || bus.rd_m !== 5'd1)
            begin failures++; $display("FAIL rst_reload: got v=%b rs=%b pc=%h rd=%0d want 1 10 a4 1", bus.valid_m, bus.result_src_m, bus.pc_plus4_m, bus.rd_m); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_store_align();
        test_load_align();
        test_stall();
        test_flush();
        test_qualify();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
